// File: rtl/spr_dma_bus_arbiter_pkg.sv
// Shared types for the sprite-DMA bus arbiter.
// Imported by spr_dma_bus_arbiter and spr_dma_bus_mux.
package spr_dma_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_RD = 3'd1,
        HALT    = 3'd2,
        ALIGN   = 3'd3,
        GRANT   = 3'd4,
        RELEASE = 3'd5
    } arb_state_t;

    localparam logic BUS_SEL_CPU = 1'b0;
    localparam logic BUS_SEL_DMA = 1'b1;

    localparam int MAX_GNT_CYCLES_DEF = 1023;

    typedef struct packed {
        logic [15:0] addr;
        logic        wn;
        logic [7:0]  wdata;
    } bus_req_t;

endpackage

// File: rtl/spr_dma_bus_mux.sv
// Shared-bus selector: steers CPU or sprite-DMA address/wn/wdata
// onto the bus from the arbiter's registered select.
module spr_dma_bus_mux
    import spr_dma_bus_arbiter_pkg::*;
(
    input  logic     sel,
    input  bus_req_t cpu,
    input  bus_req_t dma,
    output bus_req_t bus
);

    assign bus = (sel == BUS_SEL_DMA) ? dma : cpu;

endmodule

// File: rtl/spr_dma_bus_arbiter.sv
// Sprite-DMA bus arbiter: halts the 6502 via RDY and hands the bus to DMA.
// Optional grant watchdog enabled by defining SPR_DMA_WDOG_EN.
module spr_dma_bus_arbiter
    import spr_dma_bus_arbiter_pkg::*;
#(
    parameter int MAX_GNT_CYCLES = MAX_GNT_CYCLES_DEF,
    parameter int CNT_W          = 10
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_cpu_addr,
    input  logic        i_cpu_wn,
    input  logic [7:0]  i_cpu_wdata,
    output logic [7:0]  o_cpu_rdata,
    output logic        o_cpu_rdy,
    input  logic        i_spr_req,
    output logic        o_spr_gnt,
    input  logic [15:0] i_spr_addr,
    input  logic        i_spr_wn,
    input  logic [7:0]  i_spr_wdata,
    output logic [7:0]  o_spr_rdata,
    output logic [15:0] o_bus_addr,
    output logic        o_bus_wn,
    output logic [7:0]  o_bus_wdata,
    input  logic [7:0]  i_bus_rdata,
    output logic        o_dma_timeout
);

    if (2**CNT_W <= MAX_GNT_CYCLES) begin : g_cnt_w_chk
        $error("CNT_W too narrow for MAX_GNT_CYCLES");
    end

    arb_state_t state, state_nxt;
    logic       p;
    logic       bus_sel;
    logic       wdog_hit;
    logic       req_ok;
    bus_req_t   cpu_side, dma_side, bus_out;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            p       <= 1'b0;
            bus_sel <= BUS_SEL_CPU;
        end else begin
            state   <= state_nxt;
            p       <= ~p;
            bus_sel <= (state_nxt == GRANT) ? BUS_SEL_DMA : BUS_SEL_CPU;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:
                if (i_spr_req && req_ok)
                    state_nxt = i_cpu_wn ? HALT : WAIT_RD;
            // RDY cannot stop a write cycle, so wait for the next read
            WAIT_RD:
                if (!i_spr_req)
                    state_nxt = IDLE;
                else if (i_cpu_wn)
                    state_nxt = HALT;
            HALT:
                state_nxt = p ? ALIGN : GRANT;
            ALIGN:
                state_nxt = GRANT;
            GRANT:
                if (!i_spr_req || wdog_hit)
                    state_nxt = RELEASE;
            RELEASE:
                state_nxt = IDLE;
            default:
                state_nxt = IDLE;
        endcase
    end

`ifdef SPR_DMA_WDOG_EN
    logic [CNT_W-1:0] gnt_cnt;
    logic             tmo;
    logic             regnt_blk;

    assign wdog_hit = (state == GRANT) &&
                      (gnt_cnt == CNT_W'(MAX_GNT_CYCLES - 1));
    assign req_ok   = ~regnt_blk;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            gnt_cnt   <= '0;
            tmo       <= 1'b0;
            regnt_blk <= 1'b0;
        end else begin
            if (state == GRANT && state_nxt == GRANT)
                gnt_cnt <= gnt_cnt + 1'b1;
            else
                gnt_cnt <= '0;
            // a forced release stays blocked until req is seen low
            if (wdog_hit) begin
                tmo       <= 1'b1;
                regnt_blk <= 1'b1;
            end else if (!i_spr_req) begin
                regnt_blk <= 1'b0;
            end
        end
    end

    assign o_dma_timeout = tmo;
`else
    assign wdog_hit      = 1'b0;
    assign req_ok        = 1'b1;
    assign o_dma_timeout = 1'b0;
`endif

    assign o_spr_gnt = (state == GRANT);
    assign o_cpu_rdy = !((state == HALT) || (state == ALIGN) ||
                         (state == GRANT));

    assign o_cpu_rdata = i_bus_rdata;
    assign o_spr_rdata = i_bus_rdata;

    assign cpu_side = '{addr: i_cpu_addr, wn: i_cpu_wn, wdata: i_cpu_wdata};
    assign dma_side = '{addr: i_spr_addr, wn: i_spr_wn, wdata: i_spr_wdata};

    spr_dma_bus_mux u_mux (
        .sel (bus_sel),
        .cpu (cpu_side),
        .dma (dma_side),
        .bus (bus_out)
    );

    assign o_bus_addr  = bus_out.addr;
    assign o_bus_wn    = bus_out.wn;
    assign o_bus_wdata = bus_out.wdata;

endmodule

// File: tb/tb_spr_dma_bus_arbiter.sv
// Self-checking bench for spr_dma_bus_arbiter.
// Grant start/length expectations go through a scoreboard queue.
module tb_spr_dma_bus_arbiter;

    localparam int MAXG = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_wn;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        rdy;
    logic        spr_req;
    logic        gnt;
    logic [15:0] spr_addr;
    logic        spr_wn;
    logic [7:0]  spr_wdata;
    logic [7:0]  spr_rdata;
    logic [15:0] bus_addr;
    logic        bus_wn;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        tmo;

    spr_dma_bus_arbiter #(
        .MAX_GNT_CYCLES (MAXG),
        .CNT_W          (10)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cpu_addr    (cpu_addr),
        .i_cpu_wn      (cpu_wn),
        .i_cpu_wdata   (cpu_wdata),
        .o_cpu_rdata   (cpu_rdata),
        .o_cpu_rdy     (rdy),
        .i_spr_req     (spr_req),
        .o_spr_gnt     (gnt),
        .i_spr_addr    (spr_addr),
        .i_spr_wn      (spr_wn),
        .i_spr_wdata   (spr_wdata),
        .o_spr_rdata   (spr_rdata),
        .o_bus_addr    (bus_addr),
        .o_bus_wn      (bus_wn),
        .o_bus_wdata   (bus_wdata),
        .i_bus_rdata   (bus_rdata),
        .o_dma_timeout (tmo)
    );

    always #5 clk = ~clk;

    // edges since reset release; parity equals the get/put bit
    int cyc;
    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int start;
        int len;
    } gnt_exp_t;

    gnt_exp_t sbq[$];
    bit       sb_on  = 1'b1;
    bit       g_prev = 1'b0;
    int       g_start;

    always @(posedge clk) begin
        gnt_exp_t e;
        #1;
        if (sb_on && !rst) begin
            if (gnt && !g_prev) begin
                g_start = cyc;
                if (sbq.size() == 0)
                    check("gnt_unexp", sbq.size(), 1);
                else
                    check("gnt_start", cyc, sbq[0].start);
            end
            if (!gnt && g_prev && sbq.size() != 0) begin
                e = sbq.pop_front();
                check("gnt_len", cyc - g_start, e.len);
            end
        end
        g_prev = gnt;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        int guard = 0;
        while (cyc < target && guard < 2000) begin
            tick();
            guard++;
        end
        if (cyc != target) check("wait_bound", cyc, target);
    endtask

    task automatic align_parity(input int odd);
        if ((cyc % 2) != odd) tick();
    endtask

    task automatic dma(input int wr_cyc, input int len, input bit drop_halt,
                       input logic [15:0] a, input bit rereq);
        int n, s;
        spr_addr  = a;
        spr_wn    = 1'b0;
        spr_wdata = a[7:0] ^ 8'h5A;
        cpu_wn    = (wr_cyc == 0);
        spr_req   = 1'b1;
        n = cyc;
        if (wr_cyc > 0) begin
            for (int i = 0; i < wr_cyc; i++) begin
                tick();
                check("wait_rdy", rdy, 1);
                check("wait_gnt", gnt, 0);
            end
            cpu_wn = 1'b1;
            n = cyc;
        end
        s = n + 2 + ((n + 1) % 2);
        sbq.push_back('{s, drop_halt ? 1 : len});
        tick();
        check("halt_rdy", rdy, 0);
        check("halt_bus", bus_addr, cpu_addr);
        if (drop_halt) spr_req = 1'b0;
        wait_cyc(s);
        check("gnt_addr", bus_addr, a);
        check("gnt_wn", bus_wn, 0);
        check("gnt_wdata", bus_wdata, a[7:0] ^ 8'h5A);
        check("gnt_rdy", rdy, 0);
        if (!drop_halt) begin
            wait_cyc(s + len - 1);
            spr_req = 1'b0;
        end
        tick();
        check("rel_gnt", gnt, 0);
        check("rel_rdy", rdy, 1);
        check("rel_bus", bus_addr, cpu_addr);
        check("rel_wn", bus_wn, cpu_wn);
        if (rereq) begin
            spr_req = 1'b1;
            cpu_wn  = 1'b1;
        end
        tick();
        check("idle_rdy", rdy, 1);
    endtask

    initial begin
        rst       = 1'b1;
        cpu_addr  = 16'hC123;
        cpu_wn    = 1'b1;
        cpu_wdata = 8'h3C;
        spr_req   = 1'b0;
        spr_addr  = 16'h0200;
        spr_wn    = 1'b1;
        spr_wdata = 8'h00;
        bus_rdata = 8'hA7;
        #22;
        rst = 1'b0;
        #1;
        check("rst_rdy", rdy, 1);
        check("rst_gnt", gnt, 0);
        check("rst_tmo", tmo, 0);
        check("rst_bus", bus_addr, cpu_addr);
        check("rst_wdata", bus_wdata, 8'h3C);
        check("cpu_rdata", cpu_rdata, 8'hA7);
        check("spr_rdata", spr_rdata, 8'hA7);
        bus_rdata = 8'h19;
        #1;
        check("spr_rdata2", spr_rdata, 8'h19);
        tick();

        align_parity(1);
        dma(0, 4, 1'b0, 16'h2000, 1'b0);
        align_parity(0);
        dma(0, 3, 1'b0, 16'h2100, 1'b0);
        dma(3, 2, 1'b0, 16'h2200, 1'b0);
        align_parity(0);
        dma(0, 1, 1'b1, 16'h2300, 1'b0);
        dma(0, 2, 1'b0, 16'h2400, 1'b1);
        dma(0, 2, 1'b0, 16'h2500, 1'b0);

`ifdef SPR_DMA_WDOG_EN
        begin
            int n, s;
            spr_req = 1'b1;
            cpu_wn  = 1'b1;
            n = cyc;
            s = n + 2 + ((n + 1) % 2);
            sbq.push_back('{s, MAXG});
            wait_cyc(s + MAXG);
            check("wd_gnt", gnt, 0);
            check("wd_tmo", tmo, 1);
            for (int i = 0; i < 4; i++) begin
                tick();
                check("wd_hold_rdy", rdy, 1);
            end
            spr_req = 1'b0;
            tick();
            dma(0, 2, 1'b0, 16'h3100, 1'b0);
            check("wd_sticky", tmo, 1);
        end
`else
        dma(0, 513, 1'b0, 16'h3000, 1'b0);
        check("tmo_zero", tmo, 0);
`endif

        sb_on   = 1'b0;
        spr_req = 1'b1;
        cpu_wn  = 1'b1;
        for (int i = 0; i < 5 && !gnt; i++) tick();
        check("rst_pre_gnt", gnt, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_gnt", gnt, 0);
        check("arst_rdy", rdy, 1);
        check("arst_bus", bus_addr, cpu_addr);
        check("arst_tmo", tmo, 0);
        tick();
        spr_req = 1'b0;
        rst     = 1'b0;
        tick();
        sb_on = 1'b1;
        dma(0, 3, 1'b0, 16'h4000, 1'b0);

        tick();
        check("sb_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
